exec_cycle_ctrl: RTL and testbench

Multi-cycle execution-cycle sequencer driving the Fetch stage and downstream datapath. It steps each instruction through fetch, decode, execute, memory and writeback, pulsing the PC-advance and register/memory strobes in the correct cycle. It waits on a memory-ready handshake with a bounded timeout, and stops on a HALT opcode or a memory fault.

---
 rtl/exec_cycle_ctrl_if.sv | 42 ++++
 rtl/exec_cycle_ctrl.sv | 128 ++++++++++++
 tb/tb_exec_cycle_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/exec_cycle_ctrl_if.sv
// rtl/exec_cycle_ctrl_if.sv - sequencer control bus; carries `retired` when RETIRE_COUNT_EN is defined.
interface exec_cycle_ctrl_if;
  logic        run;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        branch_taken;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        ir_load;
  logic        alu_en;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [2:0]  state;
  logic        halted;
  logic        fault;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retired;

  modport master (
    input  run, instruction, mem_ready, branch_taken,
    output pc_en, pc_sel, ir_load, alu_en, mem_read, mem_write, reg_write,
           state, halted, fault, retired
  );
  modport slave (
    output run, instruction, mem_ready, branch_taken,
    input  pc_en, pc_sel, ir_load, alu_en, mem_read, mem_write, reg_write,
           state, halted, fault, retired
  );
`else
  modport master (
    input  run, instruction, mem_ready, branch_taken,
    output pc_en, pc_sel, ir_load, alu_en, mem_read, mem_write, reg_write,
           state, halted, fault
  );
  modport slave (
    output run, instruction, mem_ready, branch_taken,
    input  pc_en, pc_sel, ir_load, alu_en, mem_read, mem_write, reg_write,
           state, halted, fault
  );
`endif
endinterface

// File: rtl/exec_cycle_ctrl.sv
// rtl/exec_cycle_ctrl.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer.
// Optional retired-instruction counter enabled by RETIRE_COUNT_EN.
module exec_cycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input logic               clk,
  input logic               reset,
  exec_cycle_ctrl_if.master bus
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;
  localparam logic [2:0] S_FAULT     = 3'd7;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  logic [2:0] state_q, state_d;
  logic [5:0] op_q;
  logic [7:0] wait_q, wait_d;
  logic       pc_en_c;
  logic [1:0] pc_sel_c;
  logic       is_mem_op;
  logic       unused_instr_bits;

  assign is_mem_op         = (op_q == OP_LW) || (op_q == OP_SW);
  assign unused_instr_bits = ^bus.instruction[25:0];

  // pc_sel is only non-zero while pc_en is asserted; BEQ follows branch_taken live.
  always_comb begin
    pc_en_c  = 1'b0;
    pc_sel_c = 2'b00;
    case (state_q)
      S_EXECUTE: begin
        if (!((op_q == OP_R) || is_mem_op || (op_q == OP_HALT))) begin
          pc_en_c = 1'b1;
          if (op_q == OP_BEQ) begin
            pc_sel_c = bus.branch_taken ? 2'b01 : 2'b00;
          end else if (op_q == OP_J) begin
            pc_sel_c = 2'b10;
          end
        end
      end
      S_MEMORY:    pc_en_c = (op_q == OP_SW) && bus.mem_ready;
      S_WRITEBACK: pc_en_c = 1'b1;
      default:     pc_en_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE:   if (bus.run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (op_q == OP_R) begin
          state_d = S_WRITEBACK;
        end else if (is_mem_op) begin
          state_d = S_MEMORY;
          wait_d  = 8'd0;
        end else if (op_q == OP_HALT) begin
          state_d = S_HALT;
        end
      end
      S_MEMORY: begin
        if (bus.mem_ready) begin
          if (op_q == OP_LW) state_d = S_WRITEBACK;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = state_q;
    endcase
    // Every retiring cycle is an instruction boundary.
    if (pc_en_c) state_d = bus.run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 6'd0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_DECODE) op_q <= bus.instruction[31:26];
    end
  end

  assign bus.pc_en     = pc_en_c;
  assign bus.pc_sel    = pc_sel_c;
  assign bus.ir_load   = (state_q == S_FETCH);
  assign bus.alu_en    = (state_q == S_EXECUTE);
  assign bus.mem_read  = (state_q == S_MEMORY) && (op_q == OP_LW);
  assign bus.mem_write = (state_q == S_MEMORY) && (op_q == OP_SW);
  assign bus.reg_write = (state_q == S_WRITEBACK);
  assign bus.state     = state_q;
  assign bus.halted    = (state_q == S_HALT);
  assign bus.fault     = (state_q == S_FAULT);

`ifdef RETIRE_COUNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= 32'd0;
    end else if (pc_en_c) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign bus.retired = retired_q;
`endif
endmodule

// File: tb/tb_exec_cycle_ctrl.sv
// tb/tb_exec_cycle_ctrl.sv - randomized bench for exec_cycle_ctrl against a per-instruction latency model.
module tb_exec_cycle_ctrl;
  localparam int WMAX = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] exp_retired = 32'd0;

  exec_cycle_ctrl_if bus ();

  exec_cycle_ctrl #(.MEM_WAIT_MAX(WMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {bus.pc_en, bus.ir_load, bus.alu_en, bus.mem_read, bus.mem_write,
            bus.reg_write, bus.halted, bus.fault};
  endfunction

  task automatic check_retired(input string tag);
`ifdef RETIRE_COUNT_EN
    check(tag, bus.retired, exp_retired);
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  // Ends at a negedge with reset released and the DUT in IDLE.
  task automatic do_reset();
    bus.run          = 1'b0;
    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.instruction  = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_state", bus.state, 32'd0);
    check("reset_strobes", strobes(), 32'd0);
    check("reset_pc_sel", bus.pc_sel, 32'd0);
    exp_retired = 32'd0;
    check_retired("reset_retired");
    reset = 1'b0;
  endtask

  // Runs one instruction from FETCH entry; term returns 6/7 when it ends in HALT/FAULT.
  task automatic run_instr(input logic [31:0] ins, input int w, input logic bt,
                           input logic next_run, output int term);
    logic [5:0] op;
    int   cycles, memcyc, stalls, exp_lat;
    logic done, is_mem;
    logic [1:0] exp_sel;
    op      = ins[31:26];
    is_mem  = (op == 6'h23) || (op == 6'h2B);
    cycles  = 0;
    memcyc  = 0;
    stalls  = 0;
    done    = 1'b0;
    term    = 0;
    bus.instruction  = ins;
    bus.branch_taken = bt;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) bus.mem_ready = (stalls >= w);
      else bus.mem_ready = 1'($urandom % 2);
      #1;
      cycles++;
      if (cycles == 1) begin
        check("fetch_state", bus.state, 32'd1);
        check("fetch_ir_load", bus.ir_load, 32'd1);
      end
      if (bus.mem_read || bus.mem_write) begin
        memcyc++;
        if (!bus.mem_ready) stalls++;
      end
      if (bus.pc_en || bus.halted || bus.fault) done = 1'b1;
    end
    check("done", done, 32'd1);
    if (op == 6'h3F) begin
      term = 6;
      check("halt_latency", cycles, 32'd4);
      check("halt_state", bus.state, 32'd6);
      check("halt_strobes", strobes(), 32'h02);
    end else if (is_mem && w >= WMAX) begin
      term = 7;
      check("fault_latency", cycles, 32'(4 + WMAX));
      check("fault_state", bus.state, 32'd7);
      check("fault_mem_cycles", memcyc, 32'(WMAX));
      check("fault_strobes", strobes(), 32'h01);
    end else begin
      if (op == 6'h00)      exp_lat = 4;
      else if (op == 6'h23) exp_lat = 5 + w;
      else if (op == 6'h2B) exp_lat = 4 + w;
      else                  exp_lat = 3;
      if (op == 6'h04)      exp_sel = {1'b0, bt};
      else if (op == 6'h02) exp_sel = 2'b10;
      else                  exp_sel = 2'b00;
      check("pc_en", bus.pc_en, 32'd1);
      check("latency", cycles, 32'(exp_lat));
      check("pc_sel", bus.pc_sel, 32'(exp_sel));
      check("reg_write", bus.reg_write, 32'((op == 6'h00) || (op == 6'h23)));
      if (is_mem) check("mem_cycles", memcyc, 32'(w + 1));
      check_retired("retired");
      exp_retired = exp_retired + 32'd1;
      bus.run = next_run;
      if (!next_run) begin
        @(negedge clk);
        #1;
        check("boundary_idle", bus.state, 32'd0);
        check_retired("retired_idle");
        bus.run = 1'b1;
      end
    end
  endtask

  // Terminal states ignore run; only reset leaves them.
  task automatic terminal_hold(input int st);
    for (int i = 0; i < 5; i++) begin
      bus.run = 1'($urandom % 2);
      @(negedge clk);
      #1;
      check("terminal_state", bus.state, 32'(st));
      check("terminal_strobes", strobes(), (st == 6) ? 32'h02 : 32'h01);
      check_retired("terminal_retired");
    end
    do_reset();
    bus.run = 1'b1;
  endtask

  task automatic random_instr(output logic [31:0] ins, output int w);
    logic [5:0] nops [6];
    logic [5:0] op;
    nops = '{6'h01, 6'h08, 6'h0F, 6'h3E, 6'h22, 6'h2A};
    case ($urandom % 10)
      0, 1: op = 6'h00;
      2:    op = 6'h23;
      3:    op = 6'h2B;
      4:    op = 6'h04;
      5:    op = 6'h02;
      6:    op = ($urandom % 3 == 0) ? 6'h3F : 6'h00;
      default: op = nops[$urandom % 6];
    endcase
    ins = {op, 26'($urandom)};
    w   = ($urandom % 8 == 0) ? WMAX : int'($urandom_range(0, WMAX - 1));
  endtask

  initial begin
    int term;
    int w;
    logic [31:0] ins;
    do_reset();
    bus.run = 1'b1;

    run_instr(32'h012A4020, 0, 1'b0, 1'b1, term);
    run_instr(32'h8C880004, 3, 1'b0, 1'b1, term);
    run_instr(32'h11090003, 0, 1'b1, 1'b1, term);
    run_instr(32'h11090003, 0, 1'b0, 1'b0, term);
    run_instr(32'h8C880004, WMAX - 1, 1'b0, 1'b1, term);
    run_instr(32'h08000010, 0, 1'b1, 1'b1, term);
    run_instr(32'hAD090000, WMAX, 1'b0, 1'b1, term);
    terminal_hold(term);
    run_instr(32'hFC000000, 0, 1'b0, 1'b1, term);
    terminal_hold(term);

    for (int n = 0; n < 80; n++) begin
      random_instr(ins, w);
      run_instr(ins, w, 1'($urandom % 2), 1'($urandom % 4 != 0), term);
      if (term != 0) terminal_hold(term);
    end

    // Asynchronous reset in the middle of a stalled LW.
    bus.instruction = 32'h8C880004;
    bus.mem_ready   = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    #1;
    check("midlw_mem_read", bus.mem_read, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midlw_async_state", bus.state, 32'd0);
    check("midlw_async_strobes", strobes(), 32'd0);
    do_reset();
    bus.run = 1'b1;

    for (int n = 0; n < 5; n++) run_instr(32'h012A4020, 0, 1'b0, (n != 4), term);
    check("five_r_retired_model", exp_retired, 32'd5);
    check_retired("five_r_retired");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
